// File: rtl/rgb_patch_extractor.sv
// rgb_patch_extractor
//   Takes a raster-order RGB pixel stream and emits every fully-valid 3x3
//   window as one packed 27-sample patch, in the same bit layout as the
//   inpData bus of conv (KERNEL_SIZE = INPUT_TILE_SIZE = 3, CHANNELS = 3).
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   pix_valid / pix_ready : pixel handshake; pix_r/g/b carry one pixel
//   patch_valid / ready   : patch handshake; patch_data is the packed window
//   patch_last            : marks the final patch of a frame
//
// Patch layout: channel ch (0=R, 1=G, 2=B) lives in bits
// [(ch+1)*9*DW-1 : ch*9*DW]; window element k = 3*r + c (r=0 oldest row,
// c=0 oldest column) of that channel sits at offset (8-k)*DW, so element 0
// is the most significant sample of its channel.
module rgb_patch_extractor #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [DATA_WIDTH-1:0]      pix_r,
  input  logic [DATA_WIDTH-1:0]      pix_g,
  input  logic [DATA_WIDTH-1:0]      pix_b,
  output logic                       patch_valid,
  input  logic                       patch_ready,
  output logic [27*DATA_WIDTH-1:0]   patch_data,
  output logic                       patch_last
);

  localparam int PW = 3 * DATA_WIDTH;        // one packed pixel {B,G,R}
  localparam int BW = 27 * DATA_WIDTH;       // one packed patch
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  // Both line buffers share one memory word: upper half = row-2 (lb1),
  // lower half = row-1 (lb0).
  logic [2*PW-1:0] lb_mem [IMG_WIDTH];
  logic [2*PW-1:0] lb_rd_q;
  logic [CW-1:0]   lb_rd_addr;

  logic [PW-1:0]   win_q [9];
  logic [PW-1:0]   win_d [9];
  logic [PW-1:0]   new_col [3];
  logic [PW-1:0]   pix_word;

  logic            patch_valid_q, patch_valid_d;
  logic            patch_last_q, patch_last_d;
  logic [BW-1:0]   patch_data_q, patch_data_d;
  logic [BW-1:0]   patch_pack;

  logic            accept, produce, xfer, col_end, row_end;

  assign pix_word = {pix_b, pix_g, pix_r};

  always_comb begin
    pix_ready = !patch_valid_q || patch_ready;
    accept    = pix_valid && pix_ready;
    xfer      = patch_valid_q && patch_ready;
    col_end   = (col_q == CW'(IMG_WIDTH - 1));
    row_end   = (row_q == RW'(IMG_HEIGHT - 1));
    produce   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    patch_valid_d = patch_valid_q;
    if (produce)   patch_valid_d = 1'b1;
    else if (xfer) patch_valid_d = 1'b0;
    patch_data_d = produce ? patch_pack : patch_data_q;
    patch_last_d = produce ? (row_end && col_end) : patch_last_q;

    // The buffer read is registered, so it is issued one cycle ahead for the
    // column the next accept will use. The address only moves on accept, and
    // an accept always moves it away from the column being written.
    lb_rd_addr = reset ? '0 : col_d;
  end

  // Incoming right-hand column of the window, top (oldest row) to bottom.
  always_comb begin
    new_col[0] = lb_rd_q[2*PW-1:PW];
    new_col[1] = lb_rd_q[PW-1:0];
    new_col[2] = pix_word;
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
        win_d[3*r + 2] = new_col[r];
      end
    end
  end

  // Pack the post-shift window so the registered patch reflects the pixel
  // that completed it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    for (genvar gj = 0; gj < 9; gj++) begin : g_elem
      assign patch_pack[gi*9*DATA_WIDTH + (8-gj)*DATA_WIDTH +: DATA_WIDTH] =
        win_d[gj][gi*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      row_q         <= '0;
      patch_valid_q <= 1'b0;
      patch_last_q  <= 1'b0;
      patch_data_q  <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      patch_valid_q <= patch_valid_d;
      patch_last_q  <= patch_last_d;
      patch_data_q  <= patch_data_d;
    end
  end

  // Line buffer and window carry no reset: every entry is rewritten before
  // it can reach an emitted patch.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      lb_mem[col_q] <= {lb_rd_q[PW-1:0], pix_word};
    end
    lb_rd_q <= lb_mem[lb_rd_addr];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      win_q[k] <= win_d[k];
    end
  end

  assign patch_valid = patch_valid_q;
  assign patch_data  = patch_data_q;
  assign patch_last  = patch_last_q;

endmodule

// File: doc/rgb_patch_extractor.md
# rgb_patch_extractor

- Streams an RGB image one pixel per handshake.
- Buffers the two previous rows and emits every fully-valid 3×3 window as one packed 3-channel patch.
- Output bit layout matches `inpData` of `conv`, with KERNEL_SIZE = INPUT_TILE_SIZE = 3, 8-bit data and CHANNELS = 3.
- Sits directly upstream of `conv` and replaces file-based patch generation. A 512×512 frame yields 510×510 = 260100 patches.

## Interface
Parameters:
- `IMG_WIDTH`, 512: pixels per row, ≥ 3.
- `IMG_HEIGHT`, 512: rows per frame, ≥ 3.
- `DATA_WIDTH`, 8: bits per channel sample, signed.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `pix_valid` input 1: `pix_r`/`pix_g`/`pix_b` hold a pixel.
- `pix_ready` output 1: block accepts a pixel this cycle.
- `pix_r`, `pix_g`, `pix_b` input DATA_WIDTH each: channel samples, raster order.
- `patch_valid` output 1: `patch_data` holds a patch.
- `patch_ready` input 1: downstream accepts the patch.
- `patch_data` output 27·DATA_WIDTH: packed patch, `conv` `inpData` layout.
- `patch_last` output 1: the current patch is the final patch of the frame.

## Operation
- **Handshake.** A pixel is accepted when `pix_valid && pix_ready`. A patch is transferred when `patch_valid && patch_ready`.
- **Counters.** `col` counts 0..IMG_WIDTH−1 and `row` counts 0..IMG_HEIGHT−1. Both advance only on pixel accept.
  - At `col` = IMG_WIDTH−1, `col` wraps to 0 and `row` increments.
  - At the last pixel of the frame, both wrap to 0; the next frame starts with no gap.
- **Line buffers.** Two buffers, each IMG_WIDTH × 3·DATA_WIDTH, hold rows `row`−2 and `row`−1. On accept, the buffers at address `col` shift: lb1 ← lb0, lb0 ← new pixel.
- **Window.** 3×3 registers of 3·DATA_WIDTH bits. On accept, every window row shifts left by one column. The new right column, top to bottom, is {lb1[col], lb0[col], new pixel}.
- **Window element k.** k = 3·r + c, with r = 0 the oldest row and c = 0 the oldest column. Element 0 is image pixel (`row`−2, `col`−2); element 8 is (`row`, `col`).
- **Patch emission.** An accept with `row` ≥ 2 and `col` ≥ 2 produces a patch. Windows straddling a row boundary (`col` < 2) and windows in rows 0–1 are never emitted.
- **Packing.**
  - Channel 0 = R, 1 = G, 2 = B.
  - Channel ch occupies bits [(ch+1)·9·DW−1 : ch·9·DW].
  - Element k of channel ch occupies bits [ch·9·DW + (8−k)·DW + DW−1 : ch·9·DW + (8−k)·DW].
  - Element 0 is the MSB slice of its channel. Blue element 0 is the top byte of the whole bus.
- **`patch_last`.** Asserted with the patch produced by pixel (IMG_HEIGHT−1, IMG_WIDTH−1).
- **Arithmetic.** Samples are copied unmodified; there is no arithmetic and no sign handling.
- **Reset.**
  - Clears `row`, `col`, `patch_valid` (0), `patch_last` (0) and `patch_data` (0).
  - Line buffer and window contents are not cleared; they are overwritten before any use.
  - A reset mid-frame discards any pending patch. The next accepted pixel is (0,0) of a new frame.

## Timing
- **Latency.** The patch is registered one cycle after the accepting edge: `patch_valid` rises on the edge following the accept of the completing pixel.
- **Backpressure.** `pix_ready` = !`patch_valid` || `patch_ready`, combinational.
  - A patch is held stable (`patch_data`, `patch_last`) until transferred.
  - While a patch is held, no pixel is accepted and no state advances.
- **Simultaneous transfer and accept.** If a transfer and an accept that produces a patch occur in the same cycle, the new patch is loaded and `patch_valid` stays 1.
- **Transfer without new patch.** If a transfer occurs with no patch-producing accept, `patch_valid` falls to 0.
- **Throughput.** Sustained rate is 1 pixel/cycle with `patch_ready` held high. During steady-state rows (col ≥ 2) this gives 1 patch/cycle.
- **`reset` priority.** `reset` high overrides every handshake in the same cycle; `pix_ready` is still driven by the formula above with `patch_valid` = 0.

## Test plan
Bench parameters: IMG_WIDTH = 5, IMG_HEIGHT = 4. Pixel values: R = 16·row + col, G = R + 0x40, B = R + 0x08.

- **Basic stream.** Stream 20 pixels with `patch_ready` = 1 and `pix_valid` = 1 throughout → exactly 6 patches.
  - First patch appears one cycle after pixel (2,2) is accepted.
  - Its `patch_data`[71:0] = 0x000102101112202122 and [143:72] = 0x404142505152606162.
- **Patch order and `patch_last`.** Same stream → the six patch centres are, in order, (1,1) (1,2) (1,3) (2,1) (2,2) (2,3).
  - `patch_last` = 1 only on the sixth patch.
  - The sixth patch's red slice = 0x121314222324323334.
- **Backpressure.** Hold `patch_ready` = 0 for 5 cycles at the first patch → `pix_ready` = 0 and `patch_data` stays stable; after release, the remaining patches are bit-identical to the no-stall run.
- **Bubbles.** Drive `pix_valid` with a random 50% duty cycle → identical patch sequence; `patch_valid` never asserts without a completing accept.
- **Back-to-back frames.** Stream two frames with no gap, frame 2 values XOR 0x7F → frame 2 patches are correct and start after frame-2 pixel (2,2). No patch is formed across the frame boundary.
- **Reset mid-operation.** Assert `reset` for 1 cycle after pixel (2,3), with a patch pending → `patch_valid` = 0 on the next edge; a fresh full frame then yields the same 6 patches as the basic-stream scenario.
